// File: rtl/drenaje_salidas.sv
// ============================================================================
// drenaje_salidas: round-robin drain of output FIFOs 4-7 into one valid/ready
// stream, with saturating per-channel word counters readable via req/idx.
// Revision: 1.0
// ============================================================================
`default_nettype none

module drenaje_salidas #(
  parameter int DATA_WIDTH  = 10,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic                   empty4,
  input  logic                   empty5,
  input  logic                   empty6,
  input  logic                   empty7,
  input  logic [DATA_WIDTH-1:0]  FIFO_data_out4,
  input  logic [DATA_WIDTH-1:0]  FIFO_data_out5,
  input  logic [DATA_WIDTH-1:0]  FIFO_data_out6,
  input  logic [DATA_WIDTH-1:0]  FIFO_data_out7,
  output logic                   pop4,
  output logic                   pop5,
  output logic                   pop6,
  output logic                   pop7,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [1:0]             channel_out,
  output logic                   valid_out,
  input  logic                   ready_out,
  input  logic                   req,
  input  logic [1:0]             idx,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   count_valid,
  output logic                   busy
);

  localparam logic [1:0] S_SCAN = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] C_CNT_MAX = '1;

  logic [1:0]             r_state;
  logic [1:0]             w_next;
  logic [1:0]             r_ptr;
  logic [1:0]             r_ch;
  logic [1:0]             w_sel;
  logic                   w_found;
  logic                   w_hs;
  logic [3:0]             w_empty;
  logic [3:0]             w_pop;
  logic                   w_busy;
  logic [DATA_WIDTH-1:0]  w_fifo_data [4];
  logic [COUNT_WIDTH-1:0] r_cnt [4];
  logic [DATA_WIDTH-1:0]  r_data;
  logic [1:0]             r_chan;
  logic                   r_valid;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_count_valid;

  assign w_empty        = {empty7, empty6, empty5, empty4};
  assign w_fifo_data[0] = FIFO_data_out4;
  assign w_fifo_data[1] = FIFO_data_out5;
  assign w_fifo_data[2] = FIFO_data_out6;
  assign w_fifo_data[3] = FIFO_data_out7;
  assign w_hs           = (r_state == S_SEND) && ready_out;

  // First non-empty channel at or after the pointer, wrapping 3 -> 0.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int i = 0; i < 4; i++) begin
      if (!w_found && !w_empty[r_ptr + 2'(i)]) begin
        w_found = 1'b1;
        w_sel   = r_ptr + 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_SCAN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_SCAN:  if (w_found) w_next = S_WAIT;
      S_WAIT:  w_next = S_SEND;
      S_SEND:  if (ready_out) w_next = S_SCAN;
      default: w_next = S_SCAN;
    endcase
  end

  // Pop is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    w_pop  = 4'b0000;
    w_busy = (r_state != S_SCAN);
    if ((r_state == S_SCAN) && w_found && !reset) begin
      w_pop[w_sel] = 1'b1;
    end
  end

  assign pop4 = w_pop[0];
  assign pop5 = w_pop[1];
  assign pop6 = w_pop[2];
  assign pop7 = w_pop[3];
  assign busy = w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ch    <= 2'd0;
      r_data  <= '0;
      r_chan  <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_SCAN: if (w_found) r_ch <= w_sel;
        S_WAIT: begin
          r_data  <= w_fifo_data[r_ch];
          r_chan  <= r_ch;
          r_valid <= 1'b1;
        end
        S_SEND: if (ready_out) r_valid <= 1'b0;
        default: r_valid <= 1'b0;
      endcase
    end
  end

  // init takes priority over a same-cycle handshake for pointer and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= 2'd0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (init) begin
      r_ptr <= 2'd0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (w_hs) begin
      r_ptr <= r_ch + 2'd1;
      if (r_cnt[r_ch] != C_CNT_MAX) r_cnt[r_ch] <= r_cnt[r_ch] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count       <= '0;
      r_count_valid <= 1'b0;
    end else begin
      r_count_valid <= req;
      if (req) r_count <= r_cnt[idx];
    end
  end

  assign data_out    = r_data;
  assign channel_out = r_chan;
  assign valid_out   = r_valid;
  assign count_out   = r_count;
  assign count_valid = r_count_valid;

endmodule

`default_nettype wire

// File: tb/tb_drenaje_salidas.sv
// ============================================================================
// tb_drenaje_salidas: randomized and directed bench for drenaje_salidas with
// queue-based FIFO model and transaction-level reference.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_drenaje_salidas;

  localparam int DW   = 10;
  localparam int CW   = 5;
  localparam int CMAX = 31;

  logic          clk = 1'b0;
  logic          reset, init, ready_out, req;
  logic [1:0]    idx;
  logic [3:0]    emp;
  logic [DW-1:0] fdo [4];
  logic          pop4, pop5, pop6, pop7;
  logic [DW-1:0] data_out;
  logic [1:0]    channel_out;
  logic          valid_out, count_valid, busy;
  logic [CW-1:0] count_out;

  always #5 clk = ~clk;

  drenaje_salidas #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty4(emp[0]), .empty5(emp[1]), .empty6(emp[2]), .empty7(emp[3]),
    .FIFO_data_out4(fdo[0]), .FIFO_data_out5(fdo[1]),
    .FIFO_data_out6(fdo[2]), .FIFO_data_out7(fdo[3]),
    .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
    .data_out(data_out), .channel_out(channel_out), .valid_out(valid_out),
    .ready_out(ready_out), .req(req), .idx(idx),
    .count_out(count_out), .count_valid(count_valid), .busy(busy)
  );

  // Reference: FIFO contents, the word in flight and its age since pop,
  // round-robin pointer and counters.
  logic [DW-1:0] q [4][$];
  logic [DW-1:0] mdo [4];
  bit            inflight;
  int            age;
  logic [DW-1:0] m_word;
  int            m_ch, m_ptr;
  int            m_cnt [4];
  bit            pend;
  int            exp_cout;
  int            acc_ch [$];

  int ready_mode, req_mode, req_idx, init_prob, push_prob;
  bit force_init;
  int n_chk, n_fail;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    inflight = 0; age = 0; m_ptr = 0; pend = 0; exp_cout = 0;
    for (int c = 0; c < 4; c++) m_cnt[c] = 0;
  endtask

  task automatic cycle();
    logic [3:0] exp_pop;
    int  sel, ridx;
    bit  hs, do_req;
    @(negedge clk);
    chk("valid_out", 32'(valid_out), 32'(inflight && age >= 2));
    if (inflight && age >= 2) begin
      chk("data_out", 32'(data_out), 32'(m_word));
      chk("channel_out", 32'(channel_out), 32'(m_ch));
    end
    chk("busy", 32'(busy), 32'(inflight));
    chk("count_valid", 32'(count_valid), 32'(pend));
    chk("count_out", 32'(count_out), 32'(exp_cout));
    if (push_prob > 0 && $urandom_range(99) < push_prob) begin
      int c;
      c = $urandom_range(3);
      if (q[c].size() < 8) q[c].push_back(DW'($urandom));
    end
    case (ready_mode)
      0:       ready_out = 1'b1;
      1:       ready_out = 1'($urandom_range(1));
      default: ready_out = 1'b0;
    endcase
    do_req = (req_mode == 2) || (req_mode == 1 && $urandom_range(1) == 1);
    ridx   = (req_mode == 2) ? req_idx : int'($urandom_range(3));
    req    = do_req;
    idx    = 2'(ridx);
    init   = force_init || (init_prob > 0 && $urandom_range(999) < init_prob);
    for (int c = 0; c < 4; c++) begin
      emp[c] = (q[c].size() == 0);
      fdo[c] = mdo[c];
    end
    #1;
    exp_pop = 4'b0000;
    sel = -1;
    if (!inflight) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (sel < 0 && q[c].size() != 0) sel = c;
      end
    end
    if (sel >= 0) exp_pop[sel] = 1'b1;
    chk("pop", 32'({pop7, pop6, pop5, pop4}), 32'(exp_pop));
    // effects of the coming rising edge
    hs = inflight && age >= 2 && ready_out;
    if (do_req) begin
      pend = 1; exp_cout = m_cnt[ridx];
    end else begin
      pend = 0;
    end
    if (hs) begin
      inflight = 0;
      acc_ch.push_back(m_ch);
      if (!init) begin
        if (m_cnt[m_ch] < CMAX) m_cnt[m_ch]++;
        m_ptr = (m_ch + 1) % 4;
      end
    end
    if (init) begin
      m_ptr = 0;
      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
    end
    if (sel >= 0) begin
      m_word = q[sel].pop_front();
      m_ch = sel; mdo[sel] = m_word; inflight = 1; age = 0;
    end
    if (inflight) age++;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0 || inflight) && n < bound) begin
      cycle();
      n++;
    end
    if (n >= bound) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic read_cnt(input int ix, input int exp, input string tag);
    req_mode = 2; req_idx = ix;
    cycle();
    req_mode = 0;
    cycle();
    chk(tag, 32'(count_out), 32'(exp));
  endtask

  task automatic pulse_init();
    force_init = 1;
    cycle();
    force_init = 0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1; init = 0; ready_out = 0; req = 0; idx = 0; emp = 4'hF;
    for (int c = 0; c < 4; c++) begin fdo[c] = '0; mdo[c] = '0; end
    ready_mode = 0; req_mode = 0; req_idx = 0; init_prob = 0; push_prob = 0;
    force_init = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;

    // 1: reset while presenting 0x155
    ready_mode = 2;
    q[0].push_back(10'h155);
    repeat (4) cycle();
    chk("t1_valid_pre", 32'(valid_out), 32'd1);
    chk("t1_data_pre", 32'(data_out), 32'h155);
    #2 reset = 1;
    #1;
    chk("t1_valid_rst", 32'(valid_out), 32'd0);
    chk("t1_data_rst", 32'(data_out), 32'd0);
    chk("t1_chan_rst", 32'(channel_out), 32'd0);
    chk("t1_busy_rst", 32'(busy), 32'd0);
    chk("t1_pop_rst", 32'({pop7, pop6, pop5, pop4}), 32'd0);
    chk("t1_cv_rst", 32'(count_valid), 32'd0);
    chk("t1_cnt_rst", 32'(count_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    model_reset();
    ready_mode = 0;
    for (int i = 0; i < 4; i++) read_cnt(i, 0, "t1_cnt_zero");

    // 2: three words on FIFO5 only
    acc_ch.delete();
    q[1].push_back(10'h011); q[1].push_back(10'h012); q[1].push_back(10'h013);
    drain(30);
    chk("t2_words", 32'(acc_ch.size()), 32'd3);
    read_cnt(1, 3, "t2_cnt1");

    // 3: two words on each FIFO, order from a fresh pointer
    pulse_init();
    acc_ch.delete();
    for (int c = 0; c < 4; c++) begin
      q[c].push_back(DW'(16 * c + 1)); q[c].push_back(DW'(16 * c + 2));
    end
    drain(60);
    chk("t3_len", 32'(acc_ch.size()), 32'd8);
    for (int i = 0; i < 8 && i < acc_ch.size(); i++) chk("t3_order", 32'(acc_ch[i]), 32'(i % 4));

    // 4: back-pressure while presenting a word
    pulse_init();
    q[0].push_back(10'h2A5);
    q[1].push_back(10'h0F0);
    ready_mode = 2;
    repeat (3) cycle();
    chk("t4_valid_stall", 32'(valid_out), 32'd1);
    repeat (10) cycle();
    read_cnt(0, 0, "t4_cnt_hold");
    ready_mode = 0;
    drain(30);
    read_cnt(0, 1, "t4_cnt_after");

    // 5: counter saturation on FIFO7, then init
    for (int i = 0; i < 35; i++) q[3].push_back(DW'(i + 100));
    drain(35 * 3 + 20);
    read_cnt(3, CMAX, "t5_sat");
    pulse_init();
    read_cnt(3, 0, "t5_init");

    // 6: counter read coinciding with a handshake on channel 2
    for (int i = 0; i < 5; i++) q[2].push_back(DW'(i + 200));
    req_mode = 2; req_idx = 2;
    drain(30);
    repeat (2) cycle();
    chk("t6_cnt", 32'(count_out), 32'd5);
    req_mode = 0;

    // randomized traffic, back-pressure, reads and occasional init
    push_prob = 40; ready_mode = 1; req_mode = 1; init_prob = 5;
    repeat (2000) cycle();
    push_prob = 0; init_prob = 0; ready_mode = 0; req_mode = 0;
    drain(200);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/drenaje_salidas.md
Name: drenaje_salidas

Overview:
- Downstream consumer of the four output FIFOs (FIFO 4-7) of the completed routing module.
- Drains those FIFOs round-robin into a single valid/ready output stream, tagging each word with its source channel.
- Keeps a saturating per-channel word counter that the test/host side reads through a req/idx request interface.
- Replaces the manual pop4-pop7 driving currently done by the bench.

Parameters:
data_width  10  width of each FIFO word and of data_out
count_width  5  width of each per-channel counter and of count_out

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
init  input  1  synchronous clear of counters and round-robin pointer
empty4..empty7  input  1 each  empty flag of FIFO 4..7
FIFO_data_out4..FIFO_data_out7  input  data_width each  FIFO read data, valid the cycle after pop
pop4..pop7  output  1 each  single-cycle read strobe to FIFO 4..7
data_out  output  data_width  drained word
channel_out  output  2  source channel of data_out (0 = FIFO4 ... 3 = FIFO7)
valid_out  output  1  data_out/channel_out valid
ready_out  input  1  consumer accepts the word when valid_out & ready_out
req  input  1  counter read request
idx  input  2  counter selected by req
count_out  output  count_width  counter value returned for req
count_valid  output  1  count_out valid, one-cycle pulse
busy  output  1  high in any state other than SCAN

Behaviour:
- Reset values: all outputs 0; state SCAN; pointer 0; counters 0. A word in flight when reset asserts is discarded.
- FSM states:
  - SCAN: search channels starting at pointer, wrapping 3->0, for the first channel with empty low. If one is found: assert that channel's pop for exactly this cycle, latch ch, go to WAIT. If all four are empty: stay in SCAN with no pop.
  - WAIT: register the selected FIFO_data_out into data_out and ch into channel_out; set valid_out=1 next cycle; go to SEND.
  - SEND: hold data_out, channel_out and valid_out=1 stable until ready_out=1. On the handshake cycle: valid_out=0 next cycle, counter[ch] increments, pointer <= ch+1 (mod 4), go to SCAN.
- At most one pop asserted per cycle. No pop is issued while valid_out=1. Maximum throughput is 1 word per 3 cycles.
- The pop decision uses the empty flag of the same cycle. A FIFO that empties during WAIT or SEND is irrelevant because its word has already been popped.
- Fairness: after serving channel k, channel k+1 has the highest priority. The channel just served is never chosen twice in a row while any other channel is non-empty.
- Counters:
  - Saturate at 2^count_width-1 (31); further handshakes leave the value unchanged.
  - init=1 clears all counters and the pointer on the next edge. It does not abort a word in WAIT or SEND, but that word's increment is dropped if its handshake occurs in the same cycle as init (init wins).
- Counter read:
  - req=1 in cycle N -> count_out = counter[idx] and count_valid=1 in cycle N+1.
  - If an increment of the same counter occurs in cycle N, the pre-increment value is returned.
  - With req held high, count_out and count_valid update every cycle.
  - count_valid is 0 whenever req was 0 in the previous cycle; count_out holds its last value.
- busy=1 in WAIT and SEND.

Test Plan:
1. Reset mid-SEND (valid_out=1, data_out=0x155) -> all outputs 0 immediately; after release, state is SCAN and all counters read 0.
2. Only FIFO5 holds 3 words (0x011, 0x012, 0x013), ready_out=1 -> pop5 pulses 3 times, 3 cycles apart; data_out 0x011, 0x012, 0x013 in order with channel_out=1; req with idx=1 then returns 3.
3. All four FIFOs hold 2 words each, ready_out=1 -> channel_out sequence 0,1,2,3,0,1,2,3; never two pops in one cycle.
4. ready_out=0 for 10 cycles while valid_out=1 -> data_out stable for all 10 cycles, no pops, counter unchanged; releasing ready_out completes the handshake and increments the counter by exactly 1.
5. 35 words drained from FIFO7 -> counter 3 reads 31 (saturated); an init pulse followed by req with idx=3 returns 0.
6. req with idx=2 in the same cycle as a handshake on channel 2 (counter at 4) -> count_out=4 with count_valid=1 next cycle; the following req returns 5.
